// File: rtl/alu_writeback_stage.sv
// ALU result writeback buffer: FIFO between ALU and register file, drops illegal dst writes.
// Optional out_zero flag is built only when EBPF_WB_ZERO_FLAG_EN is defined.
module alu_writeback_stage #(
  parameter int DEPTH = 2
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        in_valid,
  output logic        in_ready,
  input  logic [63:0] in_result,
  input  logic [3:0]  in_dst,
  input  logic        in_alu32,
  output logic        out_valid,
  input  logic        out_ready,
  output logic [63:0] out_data,
  output logic [3:0]  out_dst,
  output logic        err_illegal_dst
`ifdef EBPF_WB_ZERO_FLAG_EN
  ,
  output logic        out_zero
`endif
);

  localparam int AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam int CW = AW + 1;
  localparam logic [CW-1:0] FULL_CNT = CW'(DEPTH);

  typedef struct packed {
    logic [63:0] data;
    logic [3:0]  dst;
  } entry_t;

  entry_t          mem_q [DEPTH];
  entry_t          mem_d [DEPTH];
  logic [AW-1:0]   wr_ptr_q, wr_ptr_d;
  logic [AW-1:0]   rd_ptr_q, rd_ptr_d;
  logic [CW-1:0]   count_q, count_d;
  logic            err_q, err_d;

  logic            push_s;
  logic            pop_s;
  logic            store_s;
  logic            legal_s;
  entry_t          wr_entry_s;
  entry_t          head_s;

  assign in_ready        = (count_q < FULL_CNT);
  assign out_valid       = (count_q != {CW{1'b0}});
  assign err_illegal_dst = err_q;
  assign head_s          = mem_q[rd_ptr_q];
  assign out_data        = out_valid ? head_s.data : 64'h0;
  assign out_dst         = out_valid ? head_s.dst  : 4'h0;

`ifdef EBPF_WB_ZERO_FLAG_EN
  assign out_zero = (out_data == 64'h0);
`endif

  // Transfer qualification; a reset cycle takes no transfer in either direction.
  always_comb begin
    legal_s         = (in_dst < 4'd10);
    push_s          = in_valid & in_ready & ~rst;
    pop_s           = out_valid & out_ready & ~rst;
    store_s         = push_s & legal_s;
    wr_entry_s.data = in_alu32 ? {32'h0, in_result[31:0]} : in_result;
    wr_entry_s.dst  = in_dst;
  end

  // Next-state for pointers, occupancy, error pulse and storage.
  always_comb begin
    mem_d    = mem_q;
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    count_d  = count_q;
    err_d    = push_s & ~legal_s;

    if (store_s) begin
      mem_d[wr_ptr_q] = wr_entry_s;
      wr_ptr_d        = wr_ptr_q + AW'(1);
    end else begin
      wr_ptr_d = wr_ptr_q;
    end

    if (pop_s) begin
      rd_ptr_d = rd_ptr_q + AW'(1);
    end else begin
      rd_ptr_d = rd_ptr_q;
    end

    case ({store_s, pop_s})
      2'b10:   count_d = count_q + CW'(1);
      2'b01:   count_d = count_q - CW'(1);
      default: count_d = count_q;
    endcase
  end

  // Control state register.
  always_ff @(posedge clk) begin
    if (rst) begin
      wr_ptr_q <= {AW{1'b0}};
      rd_ptr_q <= {AW{1'b0}};
      count_q  <= {CW{1'b0}};
      err_q    <= 1'b0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      count_q  <= count_d;
      err_q    <= err_d;
    end
  end

  // Entry storage keeps its contents across reset; writes are already gated by rst.
  always_ff @(posedge clk) begin
    mem_q <= mem_d;
  end

endmodule

// File: tb/tb_alu_writeback_stage.sv
// Randomized and directed bench for alu_writeback_stage against a queue-based model.
// Define EBPF_WB_ZERO_FLAG_EN for both files to also check out_zero.
module tb_alu_writeback_stage;

  localparam int DEPTH = 2;

  logic        clk = 1'b0;
  logic        rst;
  logic        in_valid;
  logic        in_ready;
  logic [63:0] in_result;
  logic [3:0]  in_dst;
  logic        in_alu32;
  logic        out_valid;
  logic        out_ready;
  logic [63:0] out_data;
  logic [3:0]  out_dst;
  logic        err_illegal_dst;
`ifdef EBPF_WB_ZERO_FLAG_EN
  logic        out_zero;
`endif

  int errors = 0;
  int checks = 0;

  logic [67:0] model_q[$];
  logic        err_exp = 1'b0;

  always #5 clk = ~clk;

  alu_writeback_stage #(.DEPTH(DEPTH)) dut (
    .clk(clk),
    .rst(rst),
    .in_valid(in_valid),
    .in_ready(in_ready),
    .in_result(in_result),
    .in_dst(in_dst),
    .in_alu32(in_alu32),
    .out_valid(out_valid),
    .out_ready(out_ready),
    .out_data(out_data),
    .out_dst(out_dst),
    .err_illegal_dst(err_illegal_dst)
`ifdef EBPF_WB_ZERO_FLAG_EN
    ,
    .out_zero(out_zero)
`endif
  );

  task automatic check_eq(input string tag, input logic [63:0] got, input logic [63:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  // Compare every output against the model's view of the buffer.
  task automatic check_outputs();
    logic [63:0] exp_data;
    logic [3:0]  exp_dst;
    exp_data = 64'h0;
    exp_dst  = 4'h0;
    if (model_q.size() > 0) begin
      exp_data = model_q[0][67:4];
      exp_dst  = model_q[0][3:0];
    end
    check_eq("in_ready",  64'(in_ready),  64'(model_q.size() < DEPTH));
    check_eq("out_valid", 64'(out_valid), 64'(model_q.size() > 0));
    check_eq("out_data",  out_data, exp_data);
    check_eq("out_dst",   64'(out_dst), 64'(exp_dst));
    check_eq("err_illegal_dst", 64'(err_illegal_dst), 64'(err_exp));
`ifdef EBPF_WB_ZERO_FLAG_EN
    check_eq("out_zero", 64'(out_zero), 64'(exp_data == 64'h0));
`endif
  endtask

  // One clock: check before the edge, then advance the model with the driven inputs.
  task automatic cycle();
    bit do_push;
    bit do_pop;
    @(negedge clk);
    check_outputs();
    @(posedge clk);
    if (rst) begin
      model_q.delete();
      err_exp = 1'b0;
    end else begin
      do_push = in_valid && (model_q.size() < DEPTH);
      do_pop  = out_ready && (model_q.size() > 0);
      if (do_pop) void'(model_q.pop_front());
      err_exp = do_push && (in_dst >= 4'd10);
      if (do_push && in_dst < 4'd10)
        model_q.push_back({(in_alu32 ? {32'h0, in_result[31:0]} : in_result), in_dst});
    end
    #1;
  endtask

  task automatic drive(input logic v, input logic [63:0] r, input logic [3:0] d,
                       input logic a32, input logic ordy);
    in_valid  = v;
    in_result = r;
    in_dst    = d;
    in_alu32  = a32;
    out_ready = ordy;
  endtask

  initial begin
    rst = 1'b1;
    drive(1'b0, 64'h0, 4'h0, 1'b0, 1'b0);
    repeat (2) cycle();
    rst = 1'b0;
    cycle();
    check_eq("reset_out_data", out_data, 64'h0);

    // Single 64-bit push, one-cycle latency
    drive(1'b1, 64'hFFFF_FFFF_FFFF_FFFB, 4'd3, 1'b0, 1'b1);
    cycle();
    drive(1'b0, 64'h0, 4'h0, 1'b0, 1'b1);
    check_eq("lat1_data", out_data, 64'hFFFF_FFFF_FFFF_FFFB);
    cycle();
    cycle();

    // 32-bit class ops zero the upper half
    drive(1'b1, 64'hFFFF_FFFF_8000_0001, 4'd1, 1'b1, 1'b1);
    cycle();
    check_eq("alu32_data", out_data, 64'h0000_0000_8000_0001);
    drive(1'b1, 64'hFFFF_FFFF_0000_0000, 4'd2, 1'b1, 1'b1);
    cycle();
    drive(1'b0, 64'h0, 4'h0, 1'b0, 1'b1);
    cycle();
    cycle();

    // Fill with output stalled, hold, then drain
    drive(1'b1, 64'd1, 4'd4, 1'b0, 1'b0);
    cycle();
    drive(1'b1, 64'd2, 4'd5, 1'b0, 1'b0);
    cycle();
    drive(1'b0, 64'h0, 4'h0, 1'b0, 1'b0);
    repeat (3) cycle();
    check_eq("full_hold_data", out_data, 64'd1);
    drive(1'b0, 64'h0, 4'h0, 1'b0, 1'b1);
    repeat (3) cycle();

    // Occupancy 1 with simultaneous push/pop across pointer wraps
    drive(1'b1, 64'd100, 4'd6, 1'b0, 1'b0);
    cycle();
    for (int i = 0; i < 20; i++) begin
      drive(1'b1, 64'(101 + i), 4'(i % 10), 1'b0, 1'b1);
      cycle();
    end
    drive(1'b0, 64'h0, 4'h0, 1'b0, 1'b1);
    repeat (2) cycle();

    // Illegal destinations, alone and coinciding with a pop
    drive(1'b1, 64'hDEAD, 4'd10, 1'b0, 1'b1);
    cycle();
    drive(1'b1, 64'hBEEF, 4'd15, 1'b0, 1'b1);
    cycle();
    drive(1'b1, 64'h77, 4'd9, 1'b0, 1'b0);
    cycle();
    drive(1'b1, 64'h88, 4'd12, 1'b0, 1'b1);
    cycle();
    drive(1'b0, 64'h0, 4'h0, 1'b0, 1'b1);
    repeat (2) cycle();

    // Reset while full with in_valid held high
    drive(1'b1, 64'hA1, 4'd1, 1'b0, 1'b0);
    repeat (2) cycle();
    rst = 1'b1;
    drive(1'b1, 64'hA2, 4'd2, 1'b0, 1'b1);
    cycle();
    rst = 1'b0;
    drive(1'b1, 64'hA3, 4'd3, 1'b0, 1'b0);
    cycle();
    check_eq("post_reset_data", out_data, 64'hA3);
    drive(1'b0, 64'h0, 4'h0, 1'b0, 1'b1);
    repeat (2) cycle();

    // Randomized traffic, with occasional reset
    for (int i = 0; i < 400; i++) begin
      rst = ($urandom_range(0, 49) == 0);
      drive(1'($urandom_range(0, 2) != 0),
            {$urandom(), $urandom()} & (($urandom_range(0, 7) == 0) ? 64'hFFFF_FFFF_0000_0000 : 64'hFFFF_FFFF_FFFF_FFFF),
            4'($urandom_range(0, 15)),
            1'($urandom_range(0, 1)),
            1'($urandom_range(0, 2) != 0));
      cycle();
    end
    rst = 1'b0;
    drive(1'b0, 64'h0, 4'h0, 1'b0, 1'b1);
    repeat (4) cycle();

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
